// File: rtl/feistel_input_fifo_if.sv
// Block transfer bus between the upstream block source / round core and the
// Feistel input FIFO. The master side supplies blocks and core status; the
// slave side (the FIFO) returns ready, the split halves and the start pulse.
interface feistel_input_fifo_if #(
  parameter int BLOCK_W = 64
);
  localparam int HALF = BLOCK_W / 2;

  // Upstream block handshake
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               in_decrypt;

  // Round core side
  logic               core_busy;
  logic [HALF-1:0]    left_out;
  logic [HALF-1:0]    right_out;
  logic               mode_out;
  logic               trigger;

  modport master (
    output in_valid, in_data, in_decrypt, core_busy,
    input  in_ready, left_out, right_out, mode_out, trigger
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, core_busy,
    output in_ready, left_out, right_out, mode_out, trigger
  );
endinterface

// File: rtl/feistel_input_fifo.sv
// Buffered front end of the Feistel datapath. Blocks enter a DEPTH-entry FIFO
// over a valid/ready handshake; the head block is split into halves, tagged
// with its encrypt/decrypt mode and handed to the round core with a one-cycle
// trigger. A small dispatcher waits for the core to acknowledge (busy rising)
// and to finish (busy falling), so only one block is ever in flight. A core
// that never acknowledges sets a sticky ack_err and its block is dropped.
module feistel_input_fifo #(
  parameter int BLOCK_W = 64,
  parameter int DEPTH   = 4,
  parameter int ACK_TO  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  feistel_input_fifo_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ack_err
);

  localparam int HALF  = BLOCK_W / 2;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ACK_W = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Each entry stores {decrypt, data} so the mode travels with its block.
  logic [BLOCK_W:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [BLOCK_W:0] head;

  state_t           state;
  logic [ACK_W-1:0] ack_cnt;

  logic             push;
  logic             pop;

  // Ready depends on occupancy only: a full FIFO refuses a block even when the
  // head is leaving in the same cycle, which keeps in_ready off the core path.
  assign bus.in_ready = (count < CNT_W'(DEPTH));

  // A flush discards both the incoming block and any dispatch this cycle.
  assign push = bus.in_valid & bus.in_ready & ~flush;
  assign pop  = (state == IDLE) & (count != '0) & ~bus.core_busy & ~flush;

  assign head = mem[rd_ptr];

  // Storage array: written on push, read combinationally at the head.
  // NOTE: the data array has no reset; occupancy is tracked by count and the
  // pointers, so stale contents are never observed and the array can map to
  // plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_decrypt, bus.in_data};
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is
  // a power of two.
  // NOTE: every sequential block uses non-blocking assignments so that all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatcher: pops the head into the output registers, pulses trigger, then
  // follows the core's busy handshake; left/right/mode hold between dispatches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ack_cnt       <= '0;
      ack_err       <= 1'b0;
      bus.trigger   <= 1'b0;
      bus.left_out  <= '0;
      bus.right_out <= '0;
      bus.mode_out  <= 1'b0;
    end else begin
      // NOTE: trigger defaults low every cycle and is raised only on the
      // dispatch edge, which makes it a single-cycle pulse by construction.
      bus.trigger <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        ack_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              bus.left_out  <= head[BLOCK_W-1:HALF];
              bus.right_out <= head[HALF-1:0];
              bus.mode_out  <= head[BLOCK_W];
              bus.trigger   <= 1'b1;
              ack_cnt       <= '0;
              state         <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (bus.core_busy) begin
              state <= WAIT_DONE;
            end else if (ack_cnt == ACK_W'(ACK_TO - 1)) begin
              // The core missed the start pulse: flag it and move on.
              ack_err <= 1'b1;
              state   <= IDLE;
            end else begin
              ack_cnt <= ack_cnt + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (!bus.core_busy) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_feistel_input_fifo.sv
// Self-checking bench for feistel_input_fifo. A queue-based reference model
// tracks stored blocks, the dispatched block, the sticky error and the core
// handshake phase; a behavioural round core answers triggers with a
// configurable delay and busy duration.
module tb_feistel_input_fifo;

  localparam int BW     = 64;
  localparam int HW     = BW / 2;
  localparam int DEPTH  = 4;
  localparam int ACK_TO = 4;
  localparam int BW2    = 128;
  localparam int DEPTH2 = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       flush2;
  logic [2:0] count;
  logic       ack_err;
  logic [3:0] count2;
  logic       ack_err2;

  int n_checks = 0;
  int n_fail   = 0;

  feistel_input_fifo_if #(.BLOCK_W(BW))  bus ();
  feistel_input_fifo_if #(.BLOCK_W(BW2)) bus2 ();

  feistel_input_fifo #(.BLOCK_W(BW), .DEPTH(DEPTH), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .count(count), .ack_err(ack_err)
  );

  feistel_input_fifo #(.BLOCK_W(BW2), .DEPTH(DEPTH2), .ACK_TO(ACK_TO)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2), .bus(bus2), .count(count2), .ack_err(ack_err2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [BW:0]   mq[$];         // stored blocks, {decrypt, data}, oldest first
  logic [HW-1:0] m_left, m_right;
  logic          m_mode, m_trig, m_err;
  int            m_phase;       // 0 free, 1 started/awaiting ack, 2 core working
  int            m_wait;

  // behavioural core state
  int c_delay = 0;
  int c_hold  = 0;

  function automatic logic [2:0] m_count();
    return 3'(mq.size());
  endfunction

  function automatic logic m_ready();
    return (mq.size() < DEPTH);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_left = '0; m_right = '0; m_mode = 0; m_trig = 0; m_err = 0;
    m_phase = 0; m_wait = 0;
  endtask

  // Advance model by one clock using the inputs now applied, then let the DUT
  // take the same edge; returns 1 time unit after the edge.
  task automatic step();
    logic [BW:0] blk;
    bit          acc;
    acc    = bus.in_valid && (mq.size() < DEPTH);
    m_trig = 1'b0;
    if (!flush) begin
      if (m_phase == 0) begin
        if (mq.size() != 0 && !bus.core_busy) begin
          blk     = mq.pop_front();
          m_left  = blk[BW-1:HW];
          m_right = blk[HW-1:0];
          m_mode  = blk[BW];
          m_trig  = 1'b1;
          m_phase = 1;
          m_wait  = 0;
        end
      end else if (m_phase == 1) begin
        if (bus.core_busy) m_phase = 2;
        else begin
          m_wait++;
          if (m_wait == ACK_TO) begin
            m_err   = 1'b1;
            m_phase = 0;
          end
        end
      end else if (!bus.core_busy) begin
        m_phase = 0;
      end
      if (acc) mq.push_back({bus.in_decrypt, bus.in_data});
    end else begin
      mq.delete();
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Behavioural core: busy rises 'delay' cycles after a trigger (0 = never)
  // and stays high for 'hold' cycles.
  task automatic core_tick(input int delay, input int hold);
    if (bus.trigger) c_delay = delay;
    else if (c_delay > 0) begin
      c_delay--;
      if (c_delay == 0) begin
        bus.core_busy = 1'b1;
        c_hold        = hold;
      end
    end else if (bus.core_busy) begin
      if (c_hold > 1) c_hold--;
      else bus.core_busy = 1'b0;
    end
  endtask

  task automatic wait_trigger(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = bus.trigger;
    end
  endtask

  task automatic apply_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.in_decrypt = 0; bus.core_busy = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_decrypt = 0; bus2.core_busy = 0;
    flush = 0; flush2 = 0; c_delay = 0; c_hold = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.in_decrypt = 0; bus.core_busy = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.in_decrypt = 0; bus2.core_busy = 0;
    flush = 0; flush2 = 0;
    rst = 1;
    #3;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if ({bus.left_out, bus.right_out, bus.mode_out, bus.trigger} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: left=%h right=%h mode=%b trig=%b want all 0",
                         bus.left_out, bus.right_out, bus.mode_out, bus.trigger); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_dispatch();
    apply_reset();
    bus.in_valid = 1; bus.in_data = 64'h0123456789ABCDEF; bus.in_decrypt = 0;
    step();
    bus.in_valid = 0;
    n_checks++; if (count !== 3'd1 || bus.trigger !== 1'b0) begin n_fail++;
      $display("FAIL single_after_push: count=%0d trig=%b want 1/0", count, bus.trigger); end
    step();
    n_checks++; if (bus.trigger !== 1'b1) begin n_fail++; $display("FAIL single_trigger: got %b want 1", bus.trigger); end
    n_checks++; if (bus.left_out !== 32'h01234567 || bus.right_out !== 32'h89ABCDEF || bus.mode_out !== 1'b0) begin
      n_fail++; $display("FAIL single_halves: left=%h right=%h mode=%b want 01234567/89abcdef/0",
                         bus.left_out, bus.right_out, bus.mode_out); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
    step();
    n_checks++; if (bus.trigger !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: trig=%b want 0", bus.trigger); end
    bus.core_busy = 1; step(); step();
    bus.core_busy = 0; step(); step();
    n_checks++; if (ack_err !== 1'b0 || bus.left_out !== 32'h01234567) begin n_fail++;
      $display("FAIL single_hold: ack_err=%b left=%h want 0/01234567", ack_err, bus.left_out); end
  endtask

  task automatic test_full();
    logic [BW:0] exp[$];
    bit          seen;
    apply_reset();
    bus.core_busy = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.in_decrypt = 1'($urandom_range(0, 1));
      exp.push_back({bus.in_decrypt, bus.in_data});
      step();
    end
    n_checks++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL full_state: count=%0d ready=%b want 4/0", count, bus.in_ready); end
    bus.in_data = {$urandom, $urandom};
    step();
    bus.in_valid = 0;
    n_checks++; if (count !== 3'd4 || count !== m_count()) begin n_fail++;
      $display("FAIL full_fifth_refused: count=%0d want 4", count); end
    bus.core_busy = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_trigger(20, seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL full_dispatch_timeout: block %0d got no trigger", i); end
      n_checks++; if ({bus.mode_out, bus.left_out, bus.right_out} !== exp[i]) begin n_fail++;
        $display("FAIL full_order: block %0d got %h want %h", i, {bus.mode_out, bus.left_out, bus.right_out}, exp[i]); end
      step(); bus.core_busy = 1; step(); step(); bus.core_busy = 0;
    end
    n_checks++; if (count !== 3'd0 || ack_err !== 1'b0) begin n_fail++;
      $display("FAIL full_drained: count=%0d ack_err=%b want 0/0", count, ack_err); end
  endtask

  task automatic test_busy_hold_wrap();
    logic [BW:0] exp[$];
    int          pushed = 0, got = 0;
    bit          busy_before;
    apply_reset();
    for (int cyc = 0; cyc < 400 && got < 9; cyc++) begin
      if (pushed < 9) begin
        bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.in_decrypt = 1'($urandom_range(0, 1));
      end else bus.in_valid = 0;
      if (bus.in_valid && bus.in_ready) begin
        exp.push_back({bus.in_decrypt, bus.in_data});
        pushed++;
      end
      busy_before = bus.core_busy;
      step();
      n_checks++; if (bus.trigger !== m_trig || count !== m_count()) begin n_fail++;
        $display("FAIL wrap_cycle: trig=%b count=%0d want %b/%0d", bus.trigger, count, m_trig, m_count()); end
      if (bus.trigger === 1'b1) begin
        n_checks++; if (busy_before) begin n_fail++; $display("FAIL wrap_trigger_while_busy: trig=1 want 0"); end
        n_checks++; if (got >= exp.size() || {bus.mode_out, bus.left_out, bus.right_out} !== exp[got]) begin
          n_fail++; $display("FAIL wrap_order: block %0d got %h", got, {bus.mode_out, bus.left_out, bus.right_out}); end
        got++;
      end
      core_tick(1, 10);
    end
    n_checks++; if (got != 9) begin n_fail++; $display("FAIL wrap_count: dispatched %0d want 9", got); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL wrap_ack_err: got %b want 0", ack_err); end
  endtask

  task automatic test_ack_timeout();
    logic [BW:0] blk_b;
    apply_reset();
    bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.in_decrypt = 0;
    step();
    bus.in_data = {$urandom, $urandom}; bus.in_decrypt = 1;
    blk_b = {1'b1, bus.in_data};
    step();
    bus.in_valid = 0;
    n_checks++; if (bus.trigger !== 1'b1) begin n_fail++; $display("FAIL ack_first_trigger: got %b want 1", bus.trigger); end
    for (int k = 1; k < ACK_TO; k++) begin
      step();
      n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL ack_early: cycle %0d ack_err=%b want 0", k, ack_err); end
    end
    step();
    n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL ack_timeout: ack_err=%b want 1", ack_err); end
    step();
    n_checks++; if (bus.trigger !== 1'b1 || {bus.mode_out, bus.left_out, bus.right_out} !== blk_b) begin n_fail++;
      $display("FAIL ack_next_dispatch: trig=%b data=%h want 1/%h", bus.trigger,
               {bus.mode_out, bus.left_out, bus.right_out}, blk_b); end
    for (int k = 0; k < 8; k++) step();
    n_checks++; if (ack_err !== 1'b1 || count !== 3'd0) begin n_fail++;
      $display("FAIL ack_sticky: ack_err=%b count=%0d want 1/0", ack_err, count); end
  endtask

  task automatic test_flush();
    logic [BW-1:0] x;
    apply_reset();
    x = {$urandom, $urandom};
    bus.in_valid = 1; bus.in_data = x; bus.in_decrypt = 1;
    step();
    bus.in_valid = 0;
    step();
    step(); bus.core_busy = 1; step();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; bus.in_decrypt = 0;
      step();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_setup_count: got %0d want 3", count); end
    bus.in_data = {$urandom, $urandom};
    flush = 1;
    step();
    flush = 0; bus.in_valid = 0;
    n_checks++; if (count !== 3'd0 || bus.trigger !== 1'b0) begin n_fail++;
      $display("FAIL flush_clear: count=%0d trig=%b want 0/0", count, bus.trigger); end
    n_checks++; if (bus.left_out !== x[BW-1:HW] || bus.right_out !== x[HW-1:0] || bus.mode_out !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold: left=%h right=%h mode=%b want %h/%h/1",
                         bus.left_out, bus.right_out, bus.mode_out, x[BW-1:HW], x[HW-1:0]); end
    bus.core_busy = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++; if (bus.trigger !== 1'b0 || count !== 3'd0) begin n_fail++;
        $display("FAIL flush_quiet: cycle %0d trig=%b count=%0d want 0/0", k, bus.trigger, count); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_data    = {$urandom, $urandom};
      bus.in_decrypt = 1'($urandom_range(0, 1));
      flush          = ($urandom_range(0, 39) == 0);
      step();
      n_checks++; if (bus.trigger !== m_trig || count !== m_count() || bus.in_ready !== m_ready()
                      || ack_err !== m_err) begin n_fail++;
        $display("FAIL rand_cycle %0d: trig=%b count=%0d ready=%b err=%b want %b/%0d/%b/%b", cyc,
                 bus.trigger, count, bus.in_ready, ack_err, m_trig, m_count(), m_ready(), m_err); end
      n_checks++; if ({bus.mode_out, bus.left_out, bus.right_out} !== {m_mode, m_left, m_right}) begin n_fail++;
        $display("FAIL rand_data %0d: got %h want %h", cyc, {bus.mode_out, bus.left_out, bus.right_out},
                 {m_mode, m_left, m_right}); end
      core_tick(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3), $urandom_range(1, 6));
    end
    flush = 0; bus.in_valid = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.in_valid = 1; bus.in_data = {$urandom, $urandom} | 64'h1; bus.in_decrypt = 1;
    step();
    bus.in_valid = 0;
    step();
    step(); bus.core_busy = 1; step();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_data = {$urandom, $urandom}; step();
    end
    bus.in_valid = 0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rstmid_setup: count=%0d want 2", count); end
    #2 rst = 1;
    #1;
    n_checks++; if (count !== 3'd0 || {bus.left_out, bus.right_out, bus.mode_out, bus.trigger} !== '0
                    || ack_err !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_clear: count=%0d left=%h right=%h mode=%b trig=%b err=%b ready=%b", count,
               bus.left_out, bus.right_out, bus.mode_out, bus.trigger, ack_err, bus.in_ready); end
    @(negedge clk);
    rst = 0; bus.core_busy = 0;
    model_clear();
    @(posedge clk);
    #1;
    // reset while the trigger pulse is high cancels it
    bus.in_valid = 1; bus.in_data = {$urandom, $urandom};
    step();
    bus.in_valid = 0;
    step();
    n_checks++; if (bus.trigger !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_trigger: got %b want 1", bus.trigger); end
    rst = 1;
    #1;
    n_checks++; if (bus.trigger !== 1'b0 || bus.left_out !== '0) begin n_fail++;
      $display("FAIL rstmid_cancel: trig=%b left=%h want 0/0", bus.trigger, bus.left_out); end
    @(negedge clk);
    rst = 0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_wide();
    apply_reset();
    bus2.in_valid = 1; bus2.in_data = 128'h0123456789ABCDEF_FEDCBA9876543210; bus2.in_decrypt = 1;
    step();
    bus2.in_valid = 0;
    n_checks++; if (count2 !== 4'd1) begin n_fail++; $display("FAIL wide_push: count=%0d want 1", count2); end
    step();
    n_checks++; if (bus2.trigger !== 1'b1 || bus2.left_out !== 64'h0123456789ABCDEF
                    || bus2.right_out !== 64'hFEDCBA9876543210 || bus2.mode_out !== 1'b1 || count2 !== 4'd0) begin
      n_fail++; $display("FAIL wide_dispatch: trig=%b left=%h right=%h mode=%b count=%0d", bus2.trigger,
                         bus2.left_out, bus2.right_out, bus2.mode_out, count2); end
    bus2.core_busy = 1;
    for (int i = 0; i < DEPTH2; i++) begin
      bus2.in_valid = 1; bus2.in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    bus2.in_valid = 0;
    n_checks++; if (count2 !== 4'd8 || bus2.in_ready !== 1'b0 || bus2.trigger !== 1'b0) begin n_fail++;
      $display("FAIL wide_full: count=%0d ready=%b trig=%b want 8/0/0", count2, bus2.in_ready, bus2.trigger); end
    bus2.core_busy = 0;
  endtask

  initial begin
    test_reset();
    test_single_dispatch();
    test_full();
    test_busy_hold_wrap();
    test_ack_timeout();
    test_flush();
    test_random();
    test_reset_mid();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
